// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding RISC-V load/store initiator for a byte-banked data memory.
module lsu_mem_port #(
    parameter int READ_LATENCY = 1,
    parameter int ADDR_BITS    = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] raddress,
    output logic [31:0] waddress,
    output logic [31:0] Datain,
    input  logic [31:0] Dataout,
    output logic [3:0]  Wr
);
    typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;
    localparam int AW1 = ADDR_BITS + 1;
    localparam logic [2:0] RL = 3'(READ_LATENCY);
    state_t state_q;
    logic        ready_q, resp_valid_q, fault_q;
    logic [2:0]  f3_q, cnt_q;
    logic [3:0]  wr_q;
    logic [31:0] rdata_q, raddr_q, waddr_q, din_q;
    logic [1:0]  span;
    logic        legal, fault;
    logic [ADDR_BITS:0] end_addr;
    logic [31:0] mask, ext;
    logic [3:0]  lanes;
    always_comb begin
        span = req_funct3[1:0] == 2'b00 ? 2'd0 : req_funct3[1:0] == 2'b01 ? 2'd1 : 2'd3;
        legal = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                       : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        // The last byte touched must not wrap past the top of the bank address space
        end_addr = {1'b0, req_addr[ADDR_BITS-1:0]} + AW1'(span);
        fault = !legal || (req_addr[31:ADDR_BITS] != '0) || end_addr[ADDR_BITS];
        mask = span == 2'd0 ? 32'h0000_00FF : span == 2'd1 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        lanes = span == 2'd0 ? 4'b0001 : span == 2'd1 ? 4'b0011 : 4'b1111;
        ext = f3_q[1] ? Dataout
            : f3_q[0] ? {{16{!f3_q[2] & Dataout[15]}}, Dataout[15:0]}
                      : {{24{!f3_q[2] & Dataout[7]}}, Dataout[7:0]};
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            rdata_q      <= '0;
            f3_q         <= '0;
            cnt_q        <= '0;
            wr_q         <= '0;
            raddr_q      <= '0;
            waddr_q      <= '0;
            din_q        <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            wr_q         <= '0;
            case (state_q)
                IDLE: if (req_valid) begin
                    ready_q <= 1'b0;
                    f3_q    <= req_funct3;
                    if (fault) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        fault_q      <= 1'b1;
                        rdata_q      <= '0;
                    end else if (req_we) begin
                        state_q <= WRITE;
                        wr_q    <= lanes;
                        waddr_q <= req_addr;
                        din_q   <= req_wdata & mask;
                    end else begin
                        state_q <= READ_WAIT;
                        raddr_q <= req_addr;
                        cnt_q   <= RL;
                    end
                end
                WRITE: begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    fault_q      <= 1'b0;
                    rdata_q      <= '0;
                end
                READ_WAIT: if (cnt_q == 3'd0) begin
                    state_q      <= RESP;
                    resp_valid_q <= 1'b1;
                    fault_q      <= 1'b0;
                    rdata_q      <= ext;
                end else begin
                    cnt_q <= cnt_q - 3'd1;
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_fault = fault_q;
    assign raddress   = raddr_q;
    assign waddress   = waddr_q;
    assign Datain     = din_q;
    assign Wr         = wr_q;
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed checks of lsu_mem_port against a flat byte-addressed memory model.
module tb_lsu_mem_port;
    localparam int RL = 1;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;
    logic        Clk = 1'b0, Reset = 1'b1, req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_fault;
    logic [31:0] resp_rdata, raddress, waddress, Datain, Dataout;
    logic [3:0]  Wr;
    int total = 0, bad = 0;
    always #5 Clk = ~Clk;
    lsu_mem_port #(.READ_LATENCY(RL), .ADDR_BITS(16)) dut (
        .Clk(Clk), .Reset(Reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .raddress(raddress), .waddress(waddress), .Datain(Datain), .Dataout(Dataout), .Wr(Wr)
    );
    // Lane k of an access at address a is the byte at a+k, modelled as one flat byte space
    logic [7:0]  mem [65536];
    logic [31:0] pipe [RL];
    function automatic logic [15:0] ix(input logic [31:0] a, input int k);
        return 16'(a[15:0] + 16'(k));
    endfunction
    always @(posedge Clk) begin
        for (int k = 0; k < 4; k++) if (Wr[k]) mem[ix(waddress, k)] <= Datain[8*k +: 8];
        pipe[0] <= {mem[ix(raddress, 3)], mem[ix(raddress, 2)], mem[ix(raddress, 1)], mem[ix(raddress, 0)]};
        for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
    end
    assign Dataout = pipe[RL-1];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic op(input string tag, input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input int elat, input logic [31:0] erd, input logic eflt,
                      input logic [3:0] ewr, input logic [31:0] ewa, input logic [31:0] edw);
        int lat, nwr;
        logic [3:0] wr;
        logic [31:0] wa, dw;
        @(negedge Clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        for (int n = 0; n < 20 && !req_ready; n++) @(negedge Clk);
        @(negedge Clk);
        req_valid = 1'b0;
        check({tag, ".busy"}, 32'(req_ready), 32'd0);
        lat = 1; nwr = 0; wr = '0; wa = '0; dw = '0;
        while (1) begin
            if (Wr != 4'b0) begin nwr++; wr = Wr; wa = waddress; dw = Datain; end
            if (resp_valid || lat >= 20) break;
            @(negedge Clk);
            lat++;
        end
        check({tag, ".lat"}, 32'(lat), 32'(elat));
        check({tag, ".rdata"}, resp_rdata, erd);
        check({tag, ".fault"}, 32'(resp_fault), 32'(eflt));
        check({tag, ".wr"}, 32'(wr), 32'(ewr));
        check({tag, ".nwr"}, 32'(nwr), ewr != 4'b0 ? 32'd1 : 32'd0);
        if (ewr != 4'b0) begin
            check({tag, ".waddr"}, wa, ewa);
            check({tag, ".din"}, dw, edw);
        end
        @(negedge Clk);
        check({tag, ".pulse"}, 32'(resp_valid), 32'd0);
        check({tag, ".ready"}, 32'(req_ready), 32'd1);
    endtask
    logic [2:0]  bf3 [3] = '{W, H, B};
    logic        bwe [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] ba  [3] = '{32'h100, 32'h203, 32'h300};
    logic [31:0] bex [3] = '{32'hDEADF0EF, 32'hFFFF8001, 32'h0};
    logic [31:0] got [3];
    initial begin
        int idx, rc, nacc, busy_bad, np;
        logic adv;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        check("rst.ready", 32'(req_ready), 32'd1);
        check("rst.valid", 32'(resp_valid), 32'd0);
        check("rst.wr", 32'(Wr), 32'd0);
        check("rst.raddr", raddress, 32'd0);
        check("rst.waddr", waddress, 32'd0);
        check("rst.din", Datain, 32'd0);
        op("sw",  1, W,  32'h100, 32'hDEADBEEF, 2, 32'h0, 0, 4'hF, 32'h100, 32'hDEADBEEF);
        op("lw",  0, W,  32'h100, 32'h0, RL+2, 32'hDEADBEEF, 0, 4'h0, 0, 0);
        op("sb",  1, B,  32'h101, 32'h123456F0, 2, 32'h0, 0, 4'h1, 32'h101, 32'h000000F0);
        op("lb",  0, B,  32'h101, 32'h0, RL+2, 32'hFFFFFFF0, 0, 4'h0, 0, 0);
        op("lbu", 0, BU, 32'h101, 32'h0, RL+2, 32'h000000F0, 0, 4'h0, 0, 0);
        op("lw2", 0, W,  32'h100, 32'h0, RL+2, 32'hDEADF0EF, 0, 4'h0, 0, 0);
        op("sh",  1, H,  32'h203, 32'h8001, 2, 32'h0, 0, 4'h3, 32'h203, 32'h00008001);
        op("lh",  0, H,  32'h203, 32'h0, RL+2, 32'hFFFF8001, 0, 4'h0, 0, 0);
        op("lhu", 0, HU, 32'h203, 32'h0, RL+2, 32'h00008001, 0, 4'h0, 0, 0);
        op("f_lw",  0, W,      32'hFFFD,  32'h0,  1, 32'h0, 1, 4'h0, 0, 0);
        check("f_lw.raddr", raddress, 32'h203);
        op("f_sw",  1, W,      32'h10000, 32'h1,  1, 32'h0, 1, 4'h0, 0, 0);
        check("f_sw.waddr", waddress, 32'h203);
        op("f_ld3", 0, 3'b011, 32'h100,   32'h0,  1, 32'h0, 1, 4'h0, 0, 0);
        op("f_st4", 1, 3'b100, 32'h100,   32'hFF, 1, 32'h0, 1, 4'h0, 0, 0);
        op("f_sh",  1, H,      32'hFFFF,  32'h1,  1, 32'h0, 1, 4'h0, 0, 0);
        check("f_st.waddr", waddress, 32'h203);
        op("sbtop", 1, B, 32'hFFFF, 32'h80, 2, 32'h0, 0, 4'h1, 32'hFFFF, 32'h80);
        op("lbtop", 0, B, 32'hFFFF, 32'h0, RL+2, 32'hFFFFFF80, 0, 4'h0, 0, 0);
        idx = 0; rc = 0; nacc = 0; busy_bad = 0; adv = 1'b0;
        req_valid = 1'b1; req_we = bwe[0]; req_funct3 = bf3[0]; req_addr = ba[0]; req_wdata = 32'h55;
        for (int c = 0; c < 60 && rc < 3; c++) begin
            if (resp_valid) begin
                if (rc < 3) got[rc] = resp_rdata;
                rc++;
            end
            if (req_valid && req_ready) begin nacc++; idx++; adv = 1'b1; end
            @(negedge Clk);
            if (adv) begin
                adv = 1'b0;
                if (req_ready) busy_bad++;
                if (idx < 3) begin
                    req_we = bwe[idx]; req_funct3 = bf3[idx]; req_addr = ba[idx];
                end else req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        check("b2b.accepts", 32'(nacc), 32'd3);
        check("b2b.resps", 32'(rc), 32'd3);
        check("b2b.busy", 32'(busy_bad), 32'd0);
        for (int i = 0; i < 3; i++) check($sformatf("b2b.rdata%0d", i), got[i], bex[i]);
        op("lw3", 0, W, 32'h100, 32'h0, RL+2, 32'hDEADF0EF, 0, 4'h0, 0, 0);
        @(negedge Clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = W; req_addr = 32'h100;
        @(negedge Clk);
        req_valid = 1'b0;
        check("mid.busy", 32'(req_ready), 32'd0);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("mid.ready", 32'(req_ready), 32'd1);
        check("mid.raddr", raddress, 32'd0);
        check("mid.rdata", resp_rdata, 32'd0);
        check("mid.wr", 32'(Wr), 32'd0);
        np = 0;
        repeat (8) begin
            @(negedge Clk);
            if (resp_valid) np++;
        end
        check("mid.nopulse", 32'(np), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
